result_drain: RTL and testbench

//  Downstream of the systolic array. Snapshots the flattened ARRAY_SIZE x ARRAY_SIZE result

---
 rtl/result_drain_if.sv | 26 ++
 rtl/result_drain.sv | 121 ++++++++++++
 tb/tb_result_drain.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/result_drain_if.sv
// SRAM write port between the result drain and the SRAM port mux.
// The drain side owns the write request, address and data.
// The mux side returns the grant that accepts a write.
interface result_drain_if #(
  parameter int DATAWIDTH  = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  sram_wr;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATAWIDTH-1:0]  sram_data;
  logic                  sram_ready;

  modport master (
    output sram_wr,
    output sram_addr,
    output sram_data,
    input  sram_ready
  );

  modport slave (
    input  sram_wr,
    input  sram_addr,
    input  sram_data,
    output sram_ready
  );
endinterface

// File: rtl/result_drain.sv
// result_drain: snapshots the flattened systolic-array result vector.
// It writes the results to SRAM one element per accepted write, starting at base_addr.
// Consecutive elements go to consecutive addresses, and the address wraps silently.
// ReLU is optional per drain, and a one-cycle done pulse marks the end of the drain.
module result_drain #(
  parameter int DATAWIDTH  = 16,
  parameter int ARRAY_SIZE = 2,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [ADDR_WIDTH-1:0]                       base_addr,
  input  logic                                        relu_en,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATAWIDTH-1:0]  data_in,
  result_drain_if.master                              sram,
  output logic                                        busy,
  output logic                                        done
);

  localparam int N     = ARRAY_SIZE * ARRAY_SIZE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [N*DATAWIDTH-1:0]  snap_r;     // results captured with start
  logic [ADDR_WIDTH-1:0]   base_r;
  logic                    relu_r;
  logic [IDX_W-1:0]        idx_r;      // element currently presented on the port

  logic                    accept_s;
  logic                    last_s;
  logic [IDX_W-1:0]        next_idx_s;

  // ReLU clamp: negative elements become zero when enabled, everything else passes untouched.
  function automatic logic [DATAWIDTH-1:0] relu_f(input logic [DATAWIDTH-1:0] x,
                                                  input logic                 en);
    logic [DATAWIDTH-1:0] r;
    if (en && x[DATAWIDTH-1]) begin
      r = {DATAWIDTH{1'b0}};
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Handshake decode: write accepted this cycle, last element reached, and the next index.
  always_comb begin
    accept_s   = sram.sram_wr & sram.sram_ready;
    last_s     = (idx_r == IDX_W'(N - 1));
    next_idx_s = idx_r + IDX_W'(1);
  end

  // Drain FSM with all outputs registered; a write is held stable until it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      snap_r         <= {(N*DATAWIDTH){1'b0}};
      base_r         <= {ADDR_WIDTH{1'b0}};
      relu_r         <= 1'b0;
      idx_r          <= {IDX_W{1'b0}};
      sram.sram_wr   <= 1'b0;
      sram.sram_addr <= {ADDR_WIDTH{1'b0}};
      sram.sram_data <= {DATAWIDTH{1'b0}};
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap_r         <= data_in;
            base_r         <= base_addr;
            relu_r         <= relu_en;
            idx_r          <= {IDX_W{1'b0}};
            sram.sram_wr   <= 1'b1;
            sram.sram_addr <= base_addr;
            sram.sram_data <= relu_f(data_in[DATAWIDTH-1:0], relu_en);
            busy           <= 1'b1;
            state_r        <= WRITE;
          end else begin
            busy           <= 1'b0;
          end
        end
        WRITE: begin
          if (accept_s) begin
            if (last_s) begin
              sram.sram_wr <= 1'b0;
              done         <= 1'b1;
              state_r      <= DONE;
            end else begin
              // Present the next element immediately so back-to-back grants see no bubble.
              idx_r          <= next_idx_s;
              sram.sram_addr <= base_r + ADDR_WIDTH'(next_idx_s);
              sram.sram_data <= relu_f(snap_r[int'(next_idx_s)*DATAWIDTH +: DATAWIDTH], relu_r);
            end
          end else begin
            sram.sram_wr <= sram.sram_wr;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          sram.sram_wr <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain.
// The model keeps a queue of pending (addr, data) writes plus busy/done flags,
// derived from the drain rules.
// Edge k is the rising edge that ends cycle k. Start is sampled at edge T.
// Element i is accepted at edge T+1+i when the port is granted.
// Done becomes visible after the edge of the final acceptance.
module tb_result_drain;
  localparam int DW = 16;
  localparam int AS = 2;
  localparam int N  = AS * AS;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          relu_en = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [N*DW-1:0] data_in = '0;
  logic          busy;
  logic          done;

  result_drain_if #(.DATAWIDTH(DW), .ADDR_WIDTH(AW)) sif ();

  result_drain #(.DATAWIDTH(DW), .ARRAY_SIZE(AS), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .relu_en   (relu_en),
    .data_in   (data_in),
    .sram      (sif),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_start  = 0;

  // Model state.
  logic [AW+DW-1:0] q[$];
  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;
  bit m_fresh = 1'b0;

  // Log of accepted writes, taken from the model.
  int          log_edge[$];
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int done_edge = -1;
  int done_cnt  = 0;

  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model step at each edge, then an output comparison on the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_fresh = 1'b1;
      end else if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (q.size() > 0) begin
        if (sif.sram_ready) begin
          log_edge.push_back(cyc);
          log_addr.push_back(q[0][AW+DW-1:DW]);
          log_data.push_back(q[0][DW-1:0]);
          void'(q.pop_front());
          if (q.size() == 0) begin
            m_done    = 1'b1;
            done_edge = cyc;
            done_cnt++;
          end
        end
      end else if (!m_busy && start) begin
        for (int k = 0; k < N; k++) begin
          logic [DW-1:0] e;
          logic [AW-1:0] a;
          e = data_in[k*DW +: DW];
          if (relu_en && e[DW-1]) e = '0;
          a = base_addr + AW'(k);
          q.push_back({a, e});
        end
        m_busy  = 1'b1;
        m_fresh = 1'b0;
      end
      @(negedge clk);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("sram_wr", 32'(sif.sram_wr), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("sram_addr", 32'(sif.sram_addr), 32'(q[0][AW+DW-1:DW]));
        chk("sram_data", 32'(sif.sram_data), 32'(q[0][DW-1:0]));
      end else if (m_fresh) begin
        chk("sram_addr_rst", 32'(sif.sram_addr), 32'd0);
        chk("sram_data_rst", 32'(sif.sram_data), 32'd0);
      end
    end
  end

  task automatic log_clear();
    log_edge.delete();
    log_addr.delete();
    log_data.delete();
    done_edge = -1;
    done_cnt  = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic r, input logic [N*DW-1:0] d);
    @(negedge clk); #1;
    start = 1'b1; base_addr = b; relu_en = r; data_in = d; sif.sram_ready = 1'b1;
    t_start = cyc + 1;
    @(negedge clk); #1;
    start = 1'b0;
    data_in = {$urandom, $urandom};
    base_addr = AW'($urandom);
    relu_en = ~r;
  endtask

  task automatic wait_idle(input bit use_pat);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!m_busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      #1;
      if (use_pat) sif.sram_ready = pat[i % 6];
    end
    chk("drain_timeout", 32'(ok), 32'd1);
    sif.sram_ready = 1'b1;
  endtask

  task automatic check_log(input string name, input logic [AW-1:0] ea[4], input logic [DW-1:0] ed[4],
                           input int eo[4], input int done_off);
    chk($sformatf("%s_count", name), 32'(log_addr.size()), 32'd4);
    if (log_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s_addr%0d", name, k), 32'(log_addr[k]), 32'(ea[k]));
        chk($sformatf("%s_data%0d", name, k), 32'(log_data[k]), 32'(ed[k]));
        chk($sformatf("%s_edge%0d", name, k), 32'(log_edge[k] - t_start), 32'(eo[k]));
      end
    end
    chk($sformatf("%s_done_edge", name), 32'(done_edge - t_start), 32'(done_off));
    chk($sformatf("%s_done_cnt", name), 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] d1, d2;
    logic [AW-1:0] ea[4];
    logic [DW-1:0] ed[4];
    int eo[4];
    d1 = {16'd4, 16'hFFFD, 16'd2, 16'd1};
    d2 = {16'h8000, 16'h0005, 16'h7FFF, 16'hABCD};
    sif.sram_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_wr", 32'(sif.sram_wr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_addr", 32'(sif.sram_addr), 32'd0);
    #1 rst = 1'b0;

    // Basic drain.
    log_clear();
    pulse_start(10'h040, 1'b0, d1);
    wait_idle(1'b0);
    ea = '{10'h040, 10'h041, 10'h042, 10'h043};
    ed = '{16'd1, 16'd2, 16'hFFFD, 16'd4};
    eo = '{1, 2, 3, 4};
    check_log("t1", ea, ed, eo, 4);

    // ReLU clamps the negative element only.
    log_clear();
    pulse_start(10'h040, 1'b1, d1);
    wait_idle(1'b0);
    ed = '{16'd1, 16'd2, 16'h0000, 16'd4};
    check_log("t2", ea, ed, eo, 4);

    // Backpressure pattern.
    log_clear();
    pulse_start(10'h040, 1'b0, d1);
    wait_idle(1'b1);
    ed = '{16'd1, 16'd2, 16'hFFFD, 16'd4};
    eo = '{1, 2, 5, 7};
    check_log("t3", ea, ed, eo, 7);

    // Address wrap.
    log_clear();
    pulse_start(10'h3FE, 1'b0, d1);
    wait_idle(1'b0);
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    eo = '{1, 2, 3, 4};
    check_log("t4", ea, ed, eo, 4);

    // Start re-pulsed at edge T+2 and in the done cycle (edge T+5) is ignored.
    log_clear();
    pulse_start(10'h040, 1'b0, d1);
    @(negedge clk); #1;
    start = 1'b1; data_in = d2; base_addr = 10'h200;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    start = 1'b1; data_in = d2; base_addr = 10'h200;
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle(1'b0);
    repeat (3) @(negedge clk);
    ea = '{10'h040, 10'h041, 10'h042, 10'h043};
    check_log("t5", ea, ed, eo, 4);
    chk("t5_idle_after", 32'(busy), 32'd0);

    // Reset mid-drain at edge T+2, then a fresh drain.
    log_clear();
    pulse_start(10'h040, 1'b0, d1);
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_wr_after_rst", 32'(sif.sram_wr), 32'd0);
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    chk("t6_data_after_rst", 32'(sif.sram_data), 32'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_partial_count", 32'(log_addr.size()), 32'd1);
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    log_clear();
    pulse_start(10'h100, 1'b0, d2);
    wait_idle(1'b0);
    ea = '{10'h100, 10'h101, 10'h102, 10'h103};
    ed = '{16'hABCD, 16'h7FFF, 16'h0005, 16'h8000};
    check_log("t6", ea, ed, eo, 4);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
